// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP controller with instruction register, bypass and
// IDCODE data registers, and control strobes for an external boundary-scan chain.
// state_o exposes the FSM state with this fixed encoding:
//   0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR,
//   7 EXIT2_DR, 8 UPD_DR, 9 SEL_IR, 10 CAP_IR, 11 SHIFT_IR, 12 EXIT1_IR,
//   13 PAUSE_IR, 14 EXIT2_IR, 15 UPD_IR
// Handshake: there is no valid/ready; every posedge of tck is one TAP step and
// tms_i/tdi_i/bsr_scan_i are sampled on that edge unconditionally.
module tap_ctrl #(
  parameter int              IR_W      = 4,
  parameter logic [31:0]     IDCODE    = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_EXTEST = '0,
  parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(1),
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(2),
  parameter logic [IR_W-1:0] OP_BYPASS = {IR_W{1'b1}}
) (
  input  logic            tck,
  input  logic            trst_n,
  input  logic            tms_i,
  input  logic            tdi_i,
  output logic            tdo_o,
  output logic            tdo_en_o,
  output logic            bsr_scan_o,
  input  logic            bsr_scan_i,
  output logic            bsr_shift_o,
  output logic            bsr_capture_o,
  output logic            bsr_update_o,
  output logic            bsr_mode_o,
  output logic [IR_W-1:0] ir_o,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_TLR      = 4'd0,
    S_RTI      = 4'd1,
    S_SEL_DR   = 4'd2,
    S_CAP_DR   = 4'd3,
    S_SHIFT_DR = 4'd4,
    S_EXIT1_DR = 4'd5,
    S_PAUSE_DR = 4'd6,
    S_EXIT2_DR = 4'd7,
    S_UPD_DR   = 4'd8,
    S_SEL_IR   = 4'd9,
    S_CAP_IR   = 4'd10,
    S_SHIFT_IR = 4'd11,
    S_EXIT1_IR = 4'd12,
    S_PAUSE_IR = 4'd13,
    S_EXIT2_IR = 4'd14,
    S_UPD_IR   = 4'd15
  } tap_state_t;

  tap_state_t      r_state;
  tap_state_t      w_next;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_shift;
  logic            r_bypass;
  logic [31:0]     r_idcode;

  logic w_sel_extest;
  logic w_sel_sample;
  logic w_sel_idcode;
  logic w_sel_bypass;
  logic w_sel_bsr;

  // Next-state function of the standard TAP state diagram.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:      w_next = tms_i ? S_TLR      : S_RTI;
      S_RTI:      w_next = tms_i ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   w_next = tms_i ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   w_next = tms_i ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_next = tms_i ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: w_next = tms_i ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: w_next = tms_i ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: w_next = tms_i ? S_UPD_DR   : S_SHIFT_DR;
      S_UPD_DR:   w_next = tms_i ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   w_next = tms_i ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   w_next = tms_i ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_next = tms_i ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: w_next = tms_i ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: w_next = tms_i ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: w_next = tms_i ? S_UPD_IR   : S_SHIFT_IR;
      S_UPD_IR:   w_next = tms_i ? S_SEL_DR   : S_RTI;
      default:    w_next = S_TLR;
    endcase
  end

  // TAP state register; trst_n forces Test-Logic-Reset from any state.
  always_ff @(posedge tck) begin
    if (!trst_n) r_state <= S_TLR;
    else         r_state <= w_next;
  end

  // Instruction path: capture 0..01, shift LSB-out, update into ir.
  // ir is forced to IDCODE on every edge that lands in TLR, so it reads
  // IDCODE for the whole time the FSM sits there.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      r_ir       <= OP_IDCODE;
      r_ir_shift <= '0;
    end else begin
      if (r_state == S_CAP_IR)        r_ir_shift <= IR_W'(1);
      else if (r_state == S_SHIFT_IR) r_ir_shift <= {tdi_i, r_ir_shift[IR_W-1:1]};
      if (w_next == S_TLR)            r_ir <= OP_IDCODE;
      else if (r_state == S_UPD_IR)   r_ir <= r_ir_shift;
    end
  end

  // Instruction decode; anything not EXTEST/SAMPLE/IDCODE falls back to bypass.
  always_comb begin
    w_sel_extest = (r_ir == OP_EXTEST);
    w_sel_sample = (r_ir == OP_SAMPLE);
    w_sel_idcode = (r_ir == OP_IDCODE);
    w_sel_bsr    = w_sel_extest | w_sel_sample;
    w_sel_bypass = (r_ir == OP_BYPASS) | ~(w_sel_bsr | w_sel_idcode);
  end

  // Internal data registers; only the selected one captures or shifts.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      r_bypass <= 1'b0;
      r_idcode <= IDCODE;
    end else if (r_state == S_CAP_DR) begin
      if (w_sel_bypass) r_bypass <= 1'b0;
      if (w_sel_idcode) r_idcode <= IDCODE;
    end else if (r_state == S_SHIFT_DR) begin
      if (w_sel_bypass) r_bypass <= tdi_i;
      if (w_sel_idcode) r_idcode <= {tdi_i, r_idcode[31:1]};
    end
  end

  // Output decode straight from current state and ir, no extra latency.
  always_comb begin
    tdo_en_o      = (r_state == S_SHIFT_DR) || (r_state == S_SHIFT_IR);
    bsr_scan_o    = tdi_i;
    bsr_shift_o   = w_sel_bsr && (r_state == S_SHIFT_DR);
    bsr_capture_o = w_sel_bsr && ((r_state == S_CAP_DR) || (r_state == S_SHIFT_DR));
    bsr_update_o  = w_sel_bsr && (r_state == S_UPD_DR);
    bsr_mode_o    = w_sel_extest;
    ir_o          = r_ir;
    state_o       = r_state;
    tdo_o         = 1'b0;
    if (r_state == S_SHIFT_IR) begin
      tdo_o = r_ir_shift[0];
    end else if (r_state == S_SHIFT_DR) begin
      if (w_sel_bsr)         tdo_o = bsr_scan_i;
      else if (w_sel_idcode) tdo_o = r_idcode[0];
      else                   tdo_o = r_bypass;
    end
  end

endmodule
